rf_access_arbiter: RTL and testbench
====================================

// Module: rf_access_arbiter
// PURPOSE
//  Shares one 8x32 register file (1 write port, 1 async read port) between two requesters, A and B.
//  Each transaction is either a read or a write. Exactly one transaction owns the file at a time.
//  A 3-state FSM sequences every transaction. It returns read data and a one-cycle ack to the winner.
//  Sits between the two client blocks and the Register_file instance.
// PARAMETERS
//  DATA_W  32  register/data width
//  ADDR_W   3  register address width (2**ADDR_W registers)
// PORTS
//  clk        in   1       rising-edge clock, single domain
//  reset      in   1       synchronous, active-high reset
//  req_a      in   1       requester A: transaction request, held until ack_a
//  we_a       in   1       A: 1=write, 0=read; stable while req_a
//  addr_a     in   ADDR_W  A: register address; stable while req_a
//  wdata_a    in   DATA_W  A: write data; stable while req_a
//  ack_a      out  1       A: one-cycle completion pulse
//  req_b/we_b/addr_b/wdata_b/ack_b  same as A, for requester B
//  rdata      out  DATA_W  read result; valid in the ack cycle of a read
//  busy       out  1       1 while state != IDLE
//  rf_we      out  1       to register file: write enable
//  rf_wAddr   out  ADDR_W  to register file: write address
//  rf_wData   out  DATA_W  to register file: write data
//  rf_rAddr   out  ADDR_W  to register file: read address
//  rf_rData   in   DATA_W  from register file: async read data
// BEHAVIOUR
//  Reset (sync, at clk edge with reset=1)
//   - state=IDLE. All outputs 0: ack_a, ack_b, rdata, busy, rf_we, rf_wAddr, rf_wData, rf_rAddr.
//   - Latched request cleared. Last-grant pointer = B, so A wins the first tie.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. Fixed 3 cycles per transaction.
//   - IDLE: if req_a|req_b, pick the winner and latch its we/addr/wdata and id; go to ACCESS. Else stay.
//   - ACCESS: drive rf_wAddr=rf_rAddr=latched addr and rf_wData=latched wdata; rf_we=latched we.
//     The write commits at the edge leaving ACCESS. On a read, rf_rData is captured into rdata at that edge.
//   - DONE: ack of the winner =1; rf_we=0; go to IDLE.
//  Output timing
//   - rf_we is high only in ACCESS, registered, glitch-free. rf_* addresses hold their last value otherwise.
//   - rdata holds its value until the next read completes; writes do not change it.
//  Handshake
//   - Requester drops req at the edge where it samples ack=1, so IDLE sees the request gone.
//   - If req stays high after ack, it is treated as a new transaction.
//   - Requests arriving outside IDLE wait; they are never lost or reordered per requester.
//  Ordering and boundaries
//   - Simultaneous req_a and req_b in IDLE: one is granted per the arbitration rule; the other is served next.
//   - Write then read to the same address (separate transactions): the read returns the new data.
//   - Address 2**ADDR_W-1 (register 7) has no special case.
//  Reset mid-transaction: a write in ACCESS is discarded. At the reset edge rf_we is forced 0 and no ack is issued.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined
//   - On a tie, grant the requester not granted last. The pointer updates on every grant.
//   - Neither side can be starved.
//  ARB_ROUND_ROBIN_EN undefined
//   - Fixed priority: A always wins a tie. The pointer logic is not built.
//   - B may starve if A requests continuously.
// TESTING
//  T1 reset: hold reset 2 cycles -> all outputs 0, busy=0; then A reads addr 0 -> rdata=32'h0, ack_a after 3 cycles.
//  T2 A writes 32'habcd1234 to reg0, then A reads reg0 -> rf_we high exactly 1 cycle; rdata=32'habcd1234 with ack_a.
//  T3 A and B request together; B writes 32'h1234cdef to reg1, A reads reg1
//     -> A served first, then B; a repeat read of reg1 returns 32'h1234cdef.
//  T4 req_a and req_b held high for 4 transactions each -> RR build: grants alternate A,B,A,B...
//     Fixed build: 4 A grants, then B.
//  T5 B writes 32'hffffaaaa to reg7; assert reset during ACCESS -> no ack_b; reg7 unchanged; busy=0 next cycle.
//  T6 A writes 32'hf9876543 to reg3; then B reads reg3 and reg0
//     -> 32'hf9876543 and last reg0 value; ack pulses exactly 1 cycle each.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
//   Shares one 8x32 register file (one write port, one async read port)
//   between two requesters, A and B. Each transaction (read or write) runs
//   through a fixed three-state sequence IDLE -> ACCESS -> DONE. The winner
//   receives a one-cycle ack in DONE. For a read, the data is valid on rdata
//   in that same cycle.
//
//   Handshake: a requester raises req_x with we_x/addr_x/wdata_x stable and
//   holds it until it samples ack_x=1. It drops req_x at that edge. If req_x
//   is still high when the arbiter is back in IDLE, that is a new transaction.
//   Requests that arrive while busy wait at the requester. None are lost.
//
//   Configuration macro: ARB_ROUND_ROBIN_EN
//     defined   - on a tie, the requester not granted last wins; the
//                 last-grant pointer updates on every grant
//     undefined - fixed priority, A always wins a tie; no pointer is built
//
//   dbg_state exposes the FSM state (0=IDLE, 1=ACCESS, 2=DONE) for checkers.

module rf_access_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  // requester A
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  // requester B
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  // shared results
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  // register file side
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData,
  // debug
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                ack_a_q;
  logic                ack_b_q;
  logic                id_b_q;     // latched winner: 1 = B, 0 = A
  logic                rf_we_q;    // latched we, high only in ACCESS
  logic [ADDR_W-1:0]   addr_q;     // latched address, drives both rf ports
  logic [DATA_W-1:0]   wdata_q;    // latched write data
  logic [DATA_W-1:0]   rdata_q;

  // Winner selection for the current IDLE cycle
  logic                grant_valid_d;
  logic                grant_b_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic                last_b_q;   // 1 = B was granted last

  // Round-robin: a tie goes to whoever was not granted last
  always_comb begin
    grant_valid_d = req_a | req_b;
    if (req_a && req_b) begin
      grant_b_d = ~last_b_q;
    end else begin
      grant_b_d = req_b;
    end
  end
`else
  // Fixed priority: A wins every tie
  always_comb begin
    grant_valid_d = req_a | req_b;
    grant_b_d     = req_b & ~req_a;
  end
`endif

  // Steer the winner's transaction fields toward the latch registers
  always_comb begin
    sel_we_d    = we_a;
    sel_addr_d  = addr_a;
    sel_wdata_d = wdata_a;
    if (grant_b_d) begin
      sel_we_d    = we_b;
      sel_addr_d  = addr_b;
      sel_wdata_d = wdata_b;
    end
  end

  // Transaction FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      id_b_q   <= 1'b0;
      rf_we_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_b_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            state_q  <= ACCESS;
            busy_q   <= 1'b1;
            id_b_q   <= grant_b_d;
            rf_we_q  <= sel_we_d;
            addr_q   <= sel_addr_d;
            wdata_q  <= sel_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_b_q <= grant_b_d;
`endif
          end
        end
        ACCESS: begin
          // The write commits in the register file at this edge. A read
          // captures the async read data here.
          state_q <= DONE;
          rf_we_q <= 1'b0;
          if (!rf_we_q) begin
            rdata_q <= rf_rData;
          end
          ack_a_q <= ~id_b_q;
          ack_b_q <=  id_b_q;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ack_a_q <= 1'b0;
          ack_b_q <= 1'b0;
          rf_we_q <= 1'b0;
        end
      endcase
    end
  end

  // Reset is synchronous to clk. Gating the registered enable with it keeps
  // rf_we clean. It also stops a write in ACCESS from committing at the
  // reset edge.
  assign rf_we     = rf_we_q & ~reset;
  assign rf_wAddr  = addr_q;
  assign rf_rAddr  = addr_q;
  assign rf_wData  = wdata_q;
  assign rdata     = rdata_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed testbench for rf_access_arbiter. It includes a behavioural 8x32
// register file with an async read and a write on the clock edge.
// Expected sequences for the tie test follow ARB_ROUND_ROBIN_EN.

module tb_rf_access_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        ack_a, ack_b;
  logic [31:0] rdata;
  logic        busy;
  logic        rf_we;
  logic [2:0]  rf_wAddr, rf_rAddr;
  logic [31:0] rf_wData, rf_rData;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf_mem [8];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- register file model ----------------
  initial begin
    for (int i = 0; i < 8; i++) rf_mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_wAddr] <= rf_wData;
  end
  assign rf_rData = rf_mem[rf_rAddr];

  rf_access_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .wdata_b   (wdata_b),
    .ack_b     (ack_b),
    .rdata     (rdata),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_wAddr  (rf_wAddr),
    .rf_wData  (rf_wData),
    .rf_rAddr  (rf_rAddr),
    .rf_rData  (rf_rData),
    .dbg_state (dbg_state)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full transaction from one side. The arbiter must be idle and the
  // other side quiet. Called just after an edge.
  task automatic txn(input bit side, input logic we, input logic [2:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
    if (side == 1'b0) begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
    end else begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
    end
    tick(); // ACCESS
    chk({tag, "_access_busy"},  busy,      32'd1);
    chk({tag, "_access_state"}, dbg_state, 32'd1);
    chk({tag, "_access_we"},    rf_we,     {31'd0, we});
    chk({tag, "_access_waddr"}, rf_wAddr,  {29'd0, addr});
    chk({tag, "_access_raddr"}, rf_rAddr,  {29'd0, addr});
    if (we) chk({tag, "_access_wdata"}, rf_wData, wd);
    chk({tag, "_access_noack"}, ack_a | ack_b, 32'd0);
    tick(); // DONE
    chk({tag, "_done_ack"},   side ? ack_b : ack_a, 32'd1);
    chk({tag, "_done_other"}, side ? ack_a : ack_b, 32'd0);
    chk({tag, "_done_we"},    rf_we, 32'd0);
    chk({tag, "_done_rdata"}, rdata, exp_rd);
    if (side == 1'b0) req_a = 1'b0; else req_b = 1'b0;
    tick(); // IDLE
    chk({tag, "_idle_ack"},  ack_a | ack_b, 32'd0);
    chk({tag, "_idle_busy"}, busy,          32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] exp_seq;   // bit g: 1 = grant g goes to B
    int         na, nb, t;

    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = 3'd0; wdata_a = 32'h0;
    req_b = 1'b0; we_b = 1'b0; addr_b = 3'd0; wdata_b = 32'h0;

    // T1: reset state, then a read of reg0
    tick();
    tick();
    chk("t1_ack_a",    ack_a,     32'd0);
    chk("t1_ack_b",    ack_b,     32'd0);
    chk("t1_rdata",    rdata,     32'd0);
    chk("t1_busy",     busy,      32'd0);
    chk("t1_rf_we",    rf_we,     32'd0);
    chk("t1_rf_waddr", rf_wAddr,  32'd0);
    chk("t1_rf_wdata", rf_wData,  32'd0);
    chk("t1_rf_raddr", rf_rAddr,  32'd0);
    chk("t1_state",    dbg_state, 32'd0);
    reset = 1'b0;
    txn(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, "t1_a_rd0");

    // T2: A writes reg0, then reads it back
    txn(1'b0, 1'b1, 3'd0, 32'habcd1234, 32'h0,        "t2_a_wr0");
    chk("t2_rf_we_after", rf_we, 32'd0);
    txn(1'b0, 1'b0, 3'd0, 32'h0,        32'habcd1234, "t2_a_rd0");
    // B reads reg0. This makes B the last grant, so A wins the next tie.
    txn(1'b1, 1'b0, 3'd0, 32'h0,        32'habcd1234, "t2_b_rd0");

    // T3: simultaneous A read reg1 and B write reg1
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd1; wdata_a = 32'h0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 3'd1; wdata_b = 32'h1234cdef;
    tick();
    chk("t3_first_we",    rf_we,    32'd0);
    chk("t3_first_raddr", rf_rAddr, 32'd1);
    tick();
    chk("t3_first_ack_a", ack_a, 32'd1);
    chk("t3_first_ack_b", ack_b, 32'd0);
    chk("t3_first_rdata", rdata, 32'h0);
    req_a = 1'b0;
    tick();
    chk("t3_gap_busy", busy, 32'd0);
    tick();
    chk("t3_second_we",    rf_we,    32'd1);
    chk("t3_second_wdata", rf_wData, 32'h1234cdef);
    tick();
    chk("t3_second_ack_b", ack_b, 32'd1);
    chk("t3_second_ack_a", ack_a, 32'd0);
    chk("t3_second_rdata", rdata, 32'h0);
    req_b = 1'b0;
    tick();
    txn(1'b0, 1'b0, 3'd1, 32'h0, 32'h1234cdef, "t3_a_rd1");

    // T4: both sides hold requests for four reads each, starting from reset
    do_reset();
    chk("t4_reset_rdata", rdata, 32'h0);
    chk("t4_reset_busy",  busy,  32'd0);
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 8'b1010_1010;
`else
    exp_seq = 8'b1111_0000;
`endif
    na = 4; nb = 4;
    req_a = 1'b1; we_a = 1'b0; addr_a = 3'd0;
    req_b = 1'b1; we_b = 1'b0; addr_b = 3'd1;
    for (int g = 0; g < 8; g++) begin
      t = 0;
      while (!(ack_a || ack_b) && t < 6) begin
        tick();
        t++;
      end
      chk($sformatf("t4_g%0d_ack_seen", g), {31'd0, ack_a | ack_b}, 32'd1);
      chk($sformatf("t4_g%0d_latency", g), t, 32'd2);
      chk($sformatf("t4_g%0d_ack_b", g), ack_b, {31'd0, exp_seq[g]});
      chk($sformatf("t4_g%0d_ack_a", g), ack_a, {31'd0, ~exp_seq[g]});
      chk($sformatf("t4_g%0d_rdata", g), rdata, exp_seq[g] ? 32'h1234cdef : 32'habcd1234);
      if (exp_seq[g]) begin
        nb--;
        if (nb == 0) req_b = 1'b0;
      end else begin
        na--;
        if (na == 0) req_a = 1'b0;
      end
      tick();
    end
    chk("t4_end_busy", busy, 32'd0);

    // T5: B writes reg7, reset lands during ACCESS
    req_b = 1'b1; we_b = 1'b1; addr_b = 3'd7; wdata_b = 32'hffffaaaa;
    tick();
    chk("t5_access_we",    rf_we,     32'd1);
    chk("t5_access_state", dbg_state, 32'd1);
    reset = 1'b1;
    req_b = 1'b0;
    #1;
    chk("t5_we_gated", rf_we, 32'd0);
    tick();
    chk("t5_rst_ack_b", ack_b,     32'd0);
    chk("t5_rst_busy",  busy,      32'd0);
    chk("t5_rst_we",    rf_we,     32'd0);
    chk("t5_rst_state", dbg_state, 32'd0);
    chk("t5_rst_rdata", rdata,     32'h0);
    reset = 1'b0;
    tick();
    chk("t5_post_ack_b", ack_b, 32'd0);
    chk("t5_post_busy",  busy,  32'd0);
    txn(1'b0, 1'b0, 3'd7, 32'h0, 32'h0, "t5_a_rd7");

    // T6: A writes reg3, B reads reg3 and reg0; reg7 has no special case
    txn(1'b0, 1'b1, 3'd3, 32'hf9876543, 32'h0,        "t6_a_wr3");
    txn(1'b1, 1'b0, 3'd3, 32'h0,        32'hf9876543, "t6_b_rd3");
    txn(1'b1, 1'b0, 3'd0, 32'h0,        32'habcd1234, "t6_b_rd0");
    txn(1'b0, 1'b1, 3'd7, 32'h77770007, 32'habcd1234, "t6_a_wr7");
    txn(1'b1, 1'b0, 3'd7, 32'h0,        32'h77770007, "t6_b_rd7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
